// File: rtl/pc_redirect_unit.sv
// pc_redirect_unit: fetch PC register and branch/jump redirect control.
// Sequences the front end through a normal redirect (flush both pipeline
// registers, load the target next cycle) or a held redirect (one extra
// bubble cycle before the target is loaded). Misaligned targets divert to
// TRAP_VEC and raise a one-cycle misalign_err pulse.
module pc_redirect_unit #(
   parameter int                    data_width = 32,
   parameter logic [data_width-1:0] RESET_PC   = data_width'(32'h0000_0000),
   parameter logic [data_width-1:0] TRAP_VEC   = data_width'(32'h0000_0100)
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  ex_valid,
   input  logic                  ex_is_branch,
   input  logic                  ex_is_jal,
   input  logic                  ex_is_jalr,
   input  logic [data_width-1:0] ex_pc,
   input  logic [data_width-1:0] ex_imm,
   input  logic                  Branch_taken,
   input  logic [data_width-1:0] JALR_target,
   input  logic                  hold_pipeline,
   input  logic                  fetch_ready,
   output logic [data_width-1:0] pc,
   output logic                  pc_valid,
   output logic                  flush_if_id,
   output logic                  flush_id_ex,
   output logic                  stall_pc,
   output logic                  misalign_err,
   output logic [15:0]           redirect_count
);

   typedef enum logic {RUN, HOLD} state_t;

   state_t                  state;
   state_t                  state_next;
   logic [data_width-1:0]   pc_next;
   logic [data_width-1:0]   target;
   logic [data_width-1:0]   target_next;
   logic                    started;
   logic                    redirect_event;
   logic [data_width-1:0]   branch_target;
   logic [data_width-1:0]   jalr_clean;
   logic [data_width-1:0]   raw_target;
   logic                    target_misaligned;
   logic [data_width-1:0]   final_target;
   logic                    flush_if_id_c;
   logic                    flush_id_ex_c;
   logic                    stall_pc_c;

   // Redirect decode and target selection; the EX inputs only matter in RUN.
   always_comb begin
      redirect_event    = (state == RUN) & ex_valid &
                          (ex_is_jal | ex_is_jalr | (ex_is_branch & Branch_taken));
      branch_target     = ex_pc + ex_imm;
      jalr_clean        = JALR_target & ~data_width'(1);
      raw_target        = ex_is_jalr ? jalr_clean : branch_target;
      target_misaligned = raw_target[1];
      final_target      = target_misaligned ? TRAP_VEC : raw_target;
   end

   // Next-state, next-PC and pipeline-control decode for the RUN/HOLD machine.
   always_comb begin
      state_next    = state;
      pc_next       = pc;
      target_next   = target;
      flush_if_id_c = 1'b0;
      flush_id_ex_c = 1'b0;
      stall_pc_c    = 1'b0;
      case (state)
         RUN: begin
            if (redirect_event) begin
               flush_if_id_c = 1'b1;
               flush_id_ex_c = 1'b1;
               if (hold_pipeline) begin
                  stall_pc_c  = 1'b1;
                  target_next = final_target;
                  state_next  = HOLD;
               end else begin
                  pc_next = final_target;
               end
            end else if (started && fetch_ready) begin
               // Only an accepted, valid request advances the PC.
               pc_next = pc + data_width'(4);
            end
         end
         HOLD: begin
            stall_pc_c    = 1'b1;
            flush_id_ex_c = 1'b1;
            pc_next       = target;
            state_next    = RUN;
         end
         default: begin
            state_next = RUN;
         end
      endcase
   end

   // Reset must silence the combinational controls immediately as well.
   assign flush_if_id = flush_if_id_c & ~rst;
   assign flush_id_ex = flush_id_ex_c & ~rst;
   assign stall_pc    = stall_pc_c & ~rst;
   assign pc_valid    = started & (state == RUN);

   // State, PC, held target, error pulse and saturating redirect counter.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state          <= RUN;
         pc             <= RESET_PC;
         target         <= '0;
         started        <= 1'b0;
         misalign_err   <= 1'b0;
         redirect_count <= 16'h0000;
      end else begin
         state        <= state_next;
         pc           <= pc_next;
         target       <= target_next;
         started      <= 1'b1;
         misalign_err <= redirect_event & target_misaligned;
         if (redirect_event && (redirect_count != 16'hFFFF)) begin
            redirect_count <= redirect_count + 16'h0001;
         end
      end
   end

endmodule

// File: tb/tb_pc_redirect_unit.sv
// tb_pc_redirect_unit: directed and randomized checks of pc_redirect_unit
// against a cycle-level behavioural model of the redirect rules.
module tb_pc_redirect_unit;

   localparam logic [31:0] RESET_PC = 32'h0000_0000;
   localparam logic [31:0] TRAP_VEC = 32'h0000_0100;

   logic        clk = 1'b0;
   logic        rst;
   logic        ex_valid, ex_is_branch, ex_is_jal, ex_is_jalr;
   logic [31:0] ex_pc, ex_imm, JALR_target;
   logic        Branch_taken, hold_pipeline, fetch_ready;
   logic [31:0] pc;
   logic        pc_valid, flush_if_id, flush_id_ex, stall_pc, misalign_err;
   logic [15:0] redirect_count;

   int checks   = 0;
   int failures = 0;
   bit verbose  = 1'b1;

   // Model of the architecturally visible behaviour.
   bit          m_hold;      // a held redirect is pending this cycle
   bit          m_started;   // at least one edge seen since reset
   logic [31:0] m_pc;
   logic [31:0] m_tgt;
   int          m_count;
   bit          m_mis;

   always #5 clk = ~clk;

   pc_redirect_unit #(
      .data_width(32),
      .RESET_PC  (RESET_PC),
      .TRAP_VEC  (TRAP_VEC)
   ) dut (
      .clk           (clk),
      .rst           (rst),
      .ex_valid      (ex_valid),
      .ex_is_branch  (ex_is_branch),
      .ex_is_jal     (ex_is_jal),
      .ex_is_jalr    (ex_is_jalr),
      .ex_pc         (ex_pc),
      .ex_imm        (ex_imm),
      .Branch_taken  (Branch_taken),
      .JALR_target   (JALR_target),
      .hold_pipeline (hold_pipeline),
      .fetch_ready   (fetch_ready),
      .pc            (pc),
      .pc_valid      (pc_valid),
      .flush_if_id   (flush_if_id),
      .flush_id_ex   (flush_id_ex),
      .stall_pc      (stall_pc),
      .misalign_err  (misalign_err),
      .redirect_count(redirect_count)
   );

   task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      checks++;
      if (observed !== expected) begin
         failures++;
         $display("FAIL %s observed=0x%08h expected=0x%08h at %0t", tag, observed, expected, $time);
      end
   endtask

   task automatic model_reset();
      m_hold    = 1'b0;
      m_started = 1'b0;
      m_pc      = RESET_PC;
      m_tgt     = 32'h0;
      m_count   = 0;
      m_mis     = 1'b0;
   endtask

   // One clock cycle: apply inputs, check combinational controls, advance
   // the model, cross the edge and check the registered outputs.
   task automatic step(input bit v, input int cls, input logic [31:0] epc, input logic [31:0] imm,
                       input bit taken, input logic [31:0] jt, input bit hold, input bit fr);
      bit          ev;
      logic [31:0] tgt;
      bit          mis;
      ex_valid      = v;
      ex_is_branch  = (cls == 1);
      ex_is_jal     = (cls == 2);
      ex_is_jalr    = (cls == 3);
      ex_pc         = epc;
      ex_imm        = imm;
      Branch_taken  = taken;
      JALR_target   = jt;
      hold_pipeline = hold;
      fetch_ready   = fr;
      #1;
      ev  = !m_hold && v && (cls == 2 || cls == 3 || (cls == 1 && taken));
      tgt = (cls == 3) ? {jt[31:1], 1'b0} : epc + imm;
      mis = tgt[1];
      if (mis) tgt = TRAP_VEC;
      check("flush_if_id", {31'b0, flush_if_id}, {31'b0, ev});
      check("flush_id_ex", {31'b0, flush_id_ex}, {31'b0, ev || m_hold});
      check("stall_pc",    {31'b0, stall_pc},    {31'b0, (ev && hold) || m_hold});
      check("pc_valid",    {31'b0, pc_valid},    {31'b0, m_started && !m_hold});
      if (m_hold) begin
         m_pc   = m_tgt;
         m_hold = 1'b0;
         m_mis  = 1'b0;
      end else if (ev) begin
         if (m_count < 65535) m_count++;
         m_mis = mis;
         if (hold) begin
            m_tgt  = tgt;
            m_hold = 1'b1;
         end else begin
            m_pc = tgt;
         end
      end else begin
         m_mis = 1'b0;
         if (m_started && fr) m_pc = m_pc + 32'd4;
      end
      m_started = 1'b1;
      @(posedge clk);
      #1;
      check("pc",             pc,                       m_pc);
      check("misalign_err",   {31'b0, misalign_err},    {31'b0, m_mis});
      check("redirect_count", {16'b0, redirect_count},  m_count);
      if (verbose)
         $display("txn v=%0d cls=%0d hold=%0d fr=%0d -> pc=0x%08h valid=%0d cnt=%0d mis=%0d",
                  v, cls, hold, fr, pc, pc_valid, redirect_count, misalign_err);
   endtask

   // Asynchronous reset applied mid-cycle; outputs must respond at once.
   task automatic apply_reset();
      rst = 1'b1;
      #1;
      check("rst_pc",     pc,                          RESET_PC);
      check("rst_count",  {16'b0, redirect_count},     32'h0);
      check("rst_valid",  {31'b0, pc_valid},           32'h0);
      check("rst_flush",  {30'b0, flush_if_id, flush_id_ex}, 32'h0);
      check("rst_stall",  {31'b0, stall_pc},           32'h0);
      check("rst_mis",    {31'b0, misalign_err},       32'h0);
      @(posedge clk);
      #1;
      rst = 1'b0;
      model_reset();
   endtask

   initial begin
      rst = 1'b0;
      ex_valid = 0; ex_is_branch = 0; ex_is_jal = 0; ex_is_jalr = 0;
      ex_pc = 0; ex_imm = 0; Branch_taken = 0; JALR_target = 0;
      hold_pipeline = 0; fetch_ready = 0;
      #2;
      apply_reset();

      // Sequential fetch after reset: 0, 4, 8, 12.
      step(0, 0, 0, 0, 0, 0, 0, 1); check("seq0", pc, 32'h0);
      check("seq0_valid", {31'b0, pc_valid}, 32'h1);
      step(0, 0, 0, 0, 0, 0, 0, 1); check("seq1", pc, 32'h4);
      step(0, 0, 0, 0, 0, 0, 0, 1); check("seq2", pc, 32'h8);
      step(0, 0, 0, 0, 0, 0, 0, 1); check("seq3", pc, 32'hC);
      step(0, 0, 0, 0, 0, 0, 1, 0); check("fr0_hold", pc, 32'hC);

      // Taken branch, no extra bubble.
      step(1, 1, 32'h40, 32'h20, 1, 0, 0, 1);
      check("br_pc", pc, 32'h60);
      check("br_count", {16'b0, redirect_count}, 32'd1);
      // Not-taken branch with hold_pipeline is not an event.
      step(1, 1, 32'h40, 32'h20, 0, 0, 1, 1); check("nt_pc", pc, 32'h64);

      // Taken branch with one bubble; JAL during HOLD is ignored.
      step(1, 1, 32'h40, 32'h20, 1, 0, 1, 1); check("hold_t1_pc", pc, 32'h64);
      step(1, 2, 32'h80, 32'h400, 0, 0, 0, 1); check("hold_t2_pc", pc, 32'h60);
      check("hold_count", {16'b0, redirect_count}, 32'd2);

      // JALR: misaligned target traps, aligned one clears bit0.
      step(1, 3, 0, 0, 0, 32'h103, 0, 1); check("jalr_trap", pc, TRAP_VEC);
      check("jalr_mis", {31'b0, misalign_err}, 32'h1);
      step(0, 0, 0, 0, 0, 0, 0, 1); check("mis_once", {31'b0, misalign_err}, 32'h0);
      step(1, 3, 0, 0, 0, 32'h201, 0, 1); check("jalr_ok", pc, 32'h200);
      check("jalr_nomis", {31'b0, misalign_err}, 32'h0);

      // Wrap at the top of the address space; redirect ignores fetch_ready.
      step(1, 2, 32'hFFFF_FF00, 32'h0000_00FC, 0, 0, 0, 1); check("wrap_pre", pc, 32'hFFFF_FFFC);
      step(0, 0, 0, 0, 0, 0, 0, 1); check("wrap", pc, 32'h0);
      step(1, 2, 32'h1000, 32'h10, 0, 0, 0, 0); check("fr0_redirect", pc, 32'h1010);

      // Randomized traffic.
      for (int i = 0; i < 1500; i++) begin
         step($urandom_range(0, 3) != 0, $urandom_range(0, 3), $urandom & 32'hFFFF_FFFC,
              $urandom_range(0, 1) ? ($urandom & 32'hFFFF_FFFE) : {24'b0, $urandom_range(0, 63), 2'b00},
              $urandom_range(0, 1), $urandom, $urandom_range(0, 1), $urandom_range(0, 3) != 0);
         if ($urandom_range(0, 199) == 0) apply_reset();
      end

      // Counter saturation.
      apply_reset();
      verbose = 1'b0;
      for (int i = 0; i < 65535; i++) step(1, 2, 32'h40, 32'h20, 0, 0, 0, 1);
      verbose = 1'b1;
      check("sat_reach", {16'b0, redirect_count}, 32'hFFFF);
      step(1, 2, 32'h40, 32'h20, 0, 0, 0, 1);
      check("sat_stay", {16'b0, redirect_count}, 32'hFFFF);

      // Reset in the middle of HOLD drops the pending target.
      step(1, 1, 32'h40, 32'h20, 1, 0, 1, 1);
      #2;
      apply_reset();
      step(0, 0, 0, 0, 0, 0, 0, 1); check("post_hold_rst_pc", pc, RESET_PC);
      step(0, 0, 0, 0, 0, 0, 0, 1); check("post_hold_rst_pc1", pc, 32'h4);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/pc_redirect_unit.md
PC_REDIRECT_UNIT -- requirements
Module: pc_redirect_unit

Interface
REQ-001 SHALL have parameter data_width, default 32, PC/target width.
REQ-002 SHALL have parameter RESET_PC, default 32'h0000_0000, fetch PC after reset.
REQ-003 SHALL have parameter TRAP_VEC, default 32'h0000_0100, redirect address on misaligned target.
REQ-004 SHALL have ports: clk  in  1  single clock, rising edge.
REQ-005 rst  in  1  asynchronous, active-high reset.
REQ-006 ex_valid  in  1  EX stage holds a valid instruction.
REQ-007 ex_is_branch / ex_is_jal / ex_is_jalr  in  1 each  EX instruction class, at most one high.
REQ-008 ex_pc  in  data_width  PC of EX instruction.
REQ-009 ex_imm  in  data_width  sign-extended branch/JAL offset.
REQ-010 Branch_taken  in  1  ALU branch condition result.
REQ-011 JALR_target  in  data_width  ALU rs1+imm sum.
REQ-012 hold_pipeline  in  1  ALU request for one extra bubble on taken branch.
REQ-013 fetch_ready  in  1  instruction memory accepts pc this cycle.
REQ-014 pc  out  data_width  registered fetch PC.
REQ-015 pc_valid  out  1  pc is a valid fetch request.
REQ-016 flush_if_id, flush_id_ex  out  1 each  kill the named pipeline register contents.
REQ-017 stall_pc  out  1  front end SHALL not advance.
REQ-018 misalign_err  out  1  one-cycle pulse on misaligned target.
REQ-019 redirect_count  out  16  saturating count of redirects taken.

Function
REQ-020 Redirect event SHALL be ex_valid & (ex_is_jal | ex_is_jalr | (ex_is_branch & Branch_taken)), evaluated only in state RUN.
REQ-021 Target SHALL be ex_pc+ex_imm (mod 2^data_width) for branch/JAL; JALR_target with bit0 cleared for JALR.
REQ-022 Target with bit1 set SHALL be replaced by TRAP_VEC and misalign_err SHALL pulse in the cycle after the event.
REQ-023 FSM states SHALL be RUN and HOLD only.
REQ-024 RUN, no event: pc <= pc+4 when fetch_ready=1, pc holds when fetch_ready=0; pc_valid=1; stall_pc=0.
REQ-025 RUN, event, hold_pipeline=0: flush_if_id=flush_id_ex=1 combinationally in event cycle T; pc <= target at T+1 regardless of fetch_ready; remain RUN.
REQ-026 RUN, event, hold_pipeline=1: flush_if_id=flush_id_ex=1 and stall_pc=1 in T; target latched into internal register; next state HOLD.
REQ-027 HOLD (one cycle, T+1): stall_pc=1, flush_id_ex=1, flush_if_id=0, pc_valid=0, pc unchanged, all EX inputs ignored; pc <= latched target at T+2; next state RUN.
REQ-028 hold_pipeline without a redirect event SHALL be ignored.
REQ-029 pc+4 SHALL wrap modulo 2^data_width (32'hFFFF_FFFC -> 0).
REQ-030 redirect_count SHALL increment by 1 per accepted event (REQ-025/026), saturate at 16'hFFFF.
REQ-031 Flush outputs SHALL be 0 in RUN when no event.

Reset
REQ-032 rst=1 SHALL asynchronously force: state RUN, pc=RESET_PC, pc_valid=0, flushes=0, stall_pc=0, misalign_err=0, redirect_count=0, target register=0.
REQ-033 pc_valid SHALL rise at first clock edge after rst deassertion; reset during HOLD SHALL discard the pending redirect.

Verification
REQ-034 Reset then fetch_ready=1 for 3 cycles -> pc 0,4,8,12; pc_valid=1 from first edge.
REQ-035 RUN, ex_pc=0x40, ex_imm=0x20, ex_is_branch=1, Branch_taken=1, hold_pipeline=0 -> both flushes high in T, pc=0x60 at T+1, redirect_count=1.
REQ-036 Same with hold_pipeline=1 -> T: flushes+stall_pc; T+1: HOLD, stall_pc=1, flush_id_ex=1, pc unchanged, new JAL ignored; T+2: pc=0x60.
REQ-037 ex_is_jalr=1, JALR_target=0x103 -> pc=0x102? bit1 set -> pc=TRAP_VEC 0x100, misalign_err pulses once; JALR_target=0x201 -> pc=0x200, no error.
REQ-038 pc=0xFFFF_FFFC, fetch_ready=1 -> pc=0; fetch_ready=0 with event -> pc still takes target next cycle.
REQ-039 Force redirect_count to 0xFFFF via 65535 events, one more event -> stays 0xFFFF; rst asserted mid-HOLD -> pc=RESET_PC immediately, count=0.
